// File: rtl/can_acf_multi_if.sv
// Header/result bus between the CAN bit-stream receiver (master) and the
// multi-bank acceptance filter (slave).
interface can_acf_multi_if #(
  parameter int IDX_W = 2
);
  // Handshake: pulse-based, there is no ready signal. A header is offered
  // by a one-cycle hdr_valid. The filter takes it only while busy is low.
  // A header offered while busy is high is dropped and hdr_overrun pulses.
  // Each header it takes produces exactly one res_valid pulse, unless
  // hdr_abort cancels it first.
  logic             hdr_valid;
  logic [28:0]      hdr_id;
  logic             hdr_ide;
  logic             hdr_rtr;
  logic             hdr_abort;
  logic             busy;
  logic             res_valid;
  logic             res_accept;
  logic [IDX_W-1:0] res_index;
  logic             hdr_overrun;
  logic [1:0]       dbg_state;

  modport master (
    output hdr_valid, hdr_id, hdr_ide, hdr_rtr, hdr_abort,
    input  busy, res_valid, res_accept, res_index, hdr_overrun, dbg_state
  );

  modport slave (
    input  hdr_valid, hdr_id, hdr_ide, hdr_rtr, hdr_abort,
    output busy, res_valid, res_accept, res_index, hdr_overrun, dbg_state
  );
endinterface

// File: rtl/can_acf_multi.sv
// Multi-bank CAN acceptance filter: sequential scan of code/mask banks, lowest match wins.
// Optional per-bank hit counters are enabled with `define CAN_ACF_HIT_COUNT_EN.
module can_acf_multi #(
  parameter int NUM_FILTERS = 4,
  parameter int IDX_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [31:0]       cfg_code,
  input  logic [31:0]       cfg_mask,
  input  logic              acf_bypass,
  can_acf_multi_if.slave    bus
`ifdef CAN_ACF_HIT_COUNT_EN
  ,
  input  logic [IDX_W-1:0]  cnt_addr,
  output logic [15:0]       cnt_data,
  input  logic              cnt_clr
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_FILTERS - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [28:0]      lat_id;
  logic             lat_ide;
  logic             lat_rtr;
  logic             acc_q;
  logic [IDX_W-1:0] idx_q;

  logic [31:0] code_q [NUM_FILTERS];
  logic [30:0] mask_q [NUM_FILTERS];

  logic [31:0] cur_code;
  logic [30:0] cur_mask;
  logic [30:0] hdr_vec;
  logic [30:0] care;
  logic        bank_hit;
  logic        unused_mask_msb;

  assign unused_mask_msb = cfg_mask[31];
  assign bus.dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_FILTERS; k++) begin
        code_q[k] <= '0;
        mask_q[k] <= '0;
      end
    end else if (cfg_we) begin
      // Addresses with no matching bank fall through and are ignored.
      for (int k = 0; k < NUM_FILTERS; k++) begin
        if (cfg_addr == IDX_W'(k)) begin
          code_q[k] <= cfg_code;
          mask_q[k] <= cfg_mask[30:0];
        end
      end
    end
  end

  // Standard frames compare only ID[10:0]; IDE and RTR are always compared.
  always_comb begin
    cur_code = code_q[ptr];
    cur_mask = mask_q[ptr];
    hdr_vec  = {lat_ide, lat_rtr, lat_id};
    care     = ~cur_mask & {2'b11, (lat_ide ? 29'h1FFF_FFFF : 29'h0000_07FF)};
    bank_hit = cur_code[31] && (((hdr_vec ^ cur_code[30:0]) & care) == 31'd0);
  end

`ifdef CAN_ACF_HIT_COUNT_EN
  logic        lat_byp;
  logic        hit_inc;
  logic [15:0] hit_cnt [NUM_FILTERS];

  assign hit_inc  = (state == S_DONE) && !bus.hdr_abort && acc_q && !lat_byp;
  assign cnt_data = (int'(cnt_addr) < NUM_FILTERS) ? hit_cnt[cnt_addr] : 16'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_byp <= 1'b0;
      for (int k = 0; k < NUM_FILTERS; k++) hit_cnt[k] <= '0;
    end else begin
      if (state == S_IDLE && bus.hdr_valid && !bus.hdr_abort) lat_byp <= acf_bypass;
      for (int k = 0; k < NUM_FILTERS; k++) begin
        if (cnt_clr) hit_cnt[k] <= '0;
        else if (hit_inc && idx_q == IDX_W'(k) && hit_cnt[k] != 16'hFFFF)
          hit_cnt[k] <= hit_cnt[k] + 16'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      ptr             <= '0;
      lat_id          <= '0;
      lat_ide         <= 1'b0;
      lat_rtr         <= 1'b0;
      acc_q           <= 1'b0;
      idx_q           <= '0;
      bus.busy        <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.res_accept  <= 1'b0;
      bus.res_index   <= '0;
      bus.hdr_overrun <= 1'b0;
    end else begin
      bus.res_valid   <= 1'b0;
      bus.hdr_overrun <= bus.hdr_valid && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.hdr_valid && !bus.hdr_abort) begin
            lat_id   <= bus.hdr_id;
            lat_ide  <= bus.hdr_ide;
            lat_rtr  <= bus.hdr_rtr;
            ptr      <= '0;
            bus.busy <= 1'b1;
            if (acf_bypass) begin
              state <= S_DONE;
              acc_q <= 1'b1;
              idx_q <= '0;
            end else begin
              state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (bus.hdr_abort) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end else if (bank_hit) begin
            state <= S_DONE;
            acc_q <= 1'b1;
            idx_q <= ptr;
          end else if (ptr == LAST) begin
            state <= S_DONE;
            acc_q <= 1'b0;
            idx_q <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          if (!bus.hdr_abort) begin
            bus.res_valid  <= 1'b1;
            bus.res_accept <= acc_q;
            bus.res_index  <= idx_q;
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
